nms_stream_window: RTL and testbench

Parametrised streaming non-maximum suppression stage for the FAST corner pipeline. It sits after the corner scorer and before the corner packer. It accepts one raster-order pixel per handshake, carrying a corner flag and a score, and generates pixel coordinates internally. It emits a suppressed corner flag for every pixel of the frame. Unlike the previous generation, it supports configurable window, score and frame sizes, valid/ready flow control, border masking, and a self-flush at end of frame.

---
 rtl/nms_stream_window.sv | 248 ++++++++++++++++++++++++
 tb/tb_nms_stream_window.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nms_stream_window.sv
// nms_stream_window: streaming non-maximum suppression for the FAST corner
// pipeline. Accepts one raster-order pixel per handshake (corner flag + score),
// keeps NMS_SIZE-1 line buffers plus an NMS_SIZE x NMS_SIZE register window,
// and emits one suppressed corner flag per frame pixel. After the last pixel it
// self-flushes R*COL_NUM+R zero pixels so the final rows complete.
//
// Ports:
//   clk, rst (async, active-low), ce (global clock enable)
//   in_vld/in_rdy handshake, in_sof, in_corner, in_score  - input pixel
//   out_vld, out_x, out_y, out_corner, out_score            - centre result
//   frame_done                                              - last pixel pulse
//
// Build option: define NMS_BORDER_SUPPRESS_EN to force out_corner=0 for
// centres closer than R to any frame edge.
module nms_stream_window #(
  parameter int unsigned COL_NUM  = 640,
  parameter int unsigned ROW_NUM  = 480,
  parameter int unsigned NMS_SIZE = 3,
  parameter int unsigned SCORE_W  = 13,
  parameter int unsigned COORD_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic               in_sof,
  input  logic               in_corner,
  input  logic [SCORE_W-1:0] in_score,
  output logic               out_vld,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_corner,
  output logic [SCORE_W-1:0] out_score,
  output logic               frame_done
);

  localparam int unsigned R         = NMS_SIZE / 2;
  localparam int unsigned PIX_W     = SCORE_W + 1;
  localparam int unsigned CX_W      = $clog2(COL_NUM);
  localparam int unsigned PR_W      = $clog2(ROW_NUM + R + 1);
  localparam int unsigned FLUSH_LEN = R * COL_NUM + R;
  localparam int unsigned FL_W      = $clog2(FLUSH_LEN + 1);

  localparam logic [CX_W-1:0] C_LAST   = CX_W'(COL_NUM - 1);
  localparam logic [PR_W-1:0] ROW_LAST = PR_W'(ROW_NUM - 1);
  localparam logic [CX_W-1:0] R_CX     = CX_W'(R);
  localparam logic [PR_W-1:0] R_PR     = PR_W'(R);
  localparam logic [FL_W-1:0] FL_LAST  = FL_W'(FLUSH_LEN - 1);
`ifdef NMS_BORDER_SUPPRESS_EN
  localparam logic [CX_W-1:0] X_HI     = CX_W'(COL_NUM - 1 - R);
  localparam logic [PR_W-1:0] Y_HI     = PR_W'(ROW_NUM - 1 - R);
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CX_W-1:0]  pc, pc_nxt, push_pc;
  logic [PR_W-1:0]  pr, pr_nxt, push_pr;
  logic [FL_W-1:0]  fl_cnt, fl_cnt_nxt;
  logic             push, rdy_nxt;
  logic [PIX_W-1:0] push_pix;

  logic             c_vld;
  logic [CX_W-1:0]  c_x;
  logic [PR_W-1:0]  c_y;

  logic             win_vld;
  logic [CX_W-1:0]  win_cx;
  logic [PR_W-1:0]  win_cy;
  logic             win_last;
  logic             keep;
  logic             later;
  logic [SCORE_W-1:0] cen_score;
  int               tx, ty;

  logic [PIX_W-1:0] lb        [NMS_SIZE-1][COL_NUM];
  logic [PIX_W-1:0] col_stack [NMS_SIZE];
  logic [PIX_W-1:0] win       [NMS_SIZE][NMS_SIZE];

  // Next state, push selection and raster counter advance (pc/pr = next push position)
  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    push_pc    = pc;
    push_pr    = pr;
    push_pix   = '0;
    pc_nxt     = pc;
    pr_nxt     = pr;
    fl_cnt_nxt = fl_cnt;
    rdy_nxt    = in_rdy;
    if (ce) begin
      case (state)
        IDLE: begin
          if (in_vld && in_rdy) begin
            push      = 1'b1;
            push_pc   = '0;
            push_pr   = '0;
            push_pix  = {in_corner, in_score};
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (in_vld && in_rdy) begin
            push     = 1'b1;
            push_pix = {in_corner, in_score};
            if (in_sof) begin
              push_pc = '0;
              push_pr = '0;
            end else if (pc == C_LAST && pr == ROW_LAST) begin
              state_nxt  = FLUSH;
              fl_cnt_nxt = '0;
            end
          end
        end
        FLUSH: begin
          push       = 1'b1;
          fl_cnt_nxt = fl_cnt + 1'b1;
          if (fl_cnt == FL_LAST) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
      if (push) begin
        if (push_pc == C_LAST) begin
          pc_nxt = '0;
          pr_nxt = push_pr + 1'b1;
        end else begin
          pc_nxt = push_pc + 1'b1;
          pr_nxt = push_pr;
        end
      end
      rdy_nxt = (state_nxt != FLUSH);
    end
  end

  // Centre of the window after this push: R rows and R columns back in raster order
  always_comb begin
    c_vld = push && ((push_pr > R_PR) || (push_pr == R_PR && push_pc >= R_CX));
    if (push_pc >= R_CX) begin
      c_x = push_pc - R_CX;
      c_y = push_pr - R_PR;
    end else begin
      c_x = push_pc + CX_W'(COL_NUM - R);
      c_y = push_pr - R_PR - 1'b1;
    end
  end

  // New window column: line-buffer rows on top, incoming pixel at the bottom
  always_comb begin
    col_stack[NMS_SIZE-1] = push_pix;
    for (int k = 0; k < int'(NMS_SIZE) - 1; k++)
      col_stack[int'(NMS_SIZE) - 2 - k] = lb[k][push_pc];
  end

  // Line buffers are not reset; stale data only ever lands on masked taps
  always_ff @(posedge clk) begin
    if (push) begin
      lb[0][push_pc] <= push_pix;
      for (int k = 1; k < int'(NMS_SIZE) - 1; k++)
        lb[k][push_pc] <= lb[k-1][push_pc];
    end
  end

  // Suppression: out-of-frame taps are ignored, which also hides column wrap.
  // Ties go to the earliest pixel in raster order.
  always_comb begin
    cen_score = win[R][R][SCORE_W-1:0];
    keep      = win[R][R][SCORE_W];
    later     = 1'b0;
    tx        = 0;
    ty        = 0;
    for (int j = 0; j < int'(NMS_SIZE); j++) begin
      for (int i = 0; i < int'(NMS_SIZE); i++) begin
        if (!(j == int'(R) && i == int'(R))) begin
          tx    = int'(win_cx) + int'(R) - j;
          ty    = int'(win_cy) - int'(R) + i;
          later = (i > int'(R)) || (i == int'(R) && j < int'(R));
          if (tx >= 0 && tx < int'(COL_NUM) && ty >= 0 && ty < int'(ROW_NUM) &&
              win[j][i][SCORE_W]) begin
            if (later) begin
              if (cen_score < win[j][i][SCORE_W-1:0]) keep = 1'b0;
            end else begin
              if (cen_score <= win[j][i][SCORE_W-1:0]) keep = 1'b0;
            end
          end
        end
      end
    end
`ifdef NMS_BORDER_SUPPRESS_EN
    if (win_cx < R_CX || win_cx > X_HI || win_cy < R_PR || win_cy > Y_HI) keep = 1'b0;
`endif
  end

  assign win_last = (win_cx == C_LAST) && (win_cy == ROW_LAST);

  // State, counters, window shift and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= '0;
      pr         <= '0;
      fl_cnt     <= '0;
      in_rdy     <= 1'b0;
      win_vld    <= 1'b0;
      win_cx     <= '0;
      win_cy     <= '0;
      for (int j = 0; j < int'(NMS_SIZE); j++)
        for (int i = 0; i < int'(NMS_SIZE); i++)
          win[j][i] <= '0;
      out_vld    <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_corner <= 1'b0;
      out_score  <= '0;
      frame_done <= 1'b0;
    end else if (ce) begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pr      <= pr_nxt;
      fl_cnt  <= fl_cnt_nxt;
      in_rdy  <= rdy_nxt;
      win_vld <= c_vld;
      if (push) begin
        win_cx <= c_x;
        win_cy <= c_y;
        for (int i = 0; i < int'(NMS_SIZE); i++) begin
          win[0][i] <= col_stack[i];
          for (int j = 1; j < int'(NMS_SIZE); j++)
            win[j][i] <= win[j-1][i];
        end
      end
      out_vld    <= win_vld;
      frame_done <= win_vld & win_last;
      if (win_vld) begin
        out_x      <= COORD_W'(win_cx);
        out_y      <= COORD_W'(win_cy);
        out_corner <= keep;
        out_score  <= cen_score;
      end
    end else begin
      out_vld    <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nms_stream_window.sv
// Directed bench for nms_stream_window on an 8x6 frame with a 3x3 window.
module tb_nms_stream_window;

  localparam int C    = 8;
  localparam int ROWS = 6;
  localparam int N    = C * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic        in_sof = 1'b0;
  logic        in_corner = 1'b0;
  logic [12:0] in_score = '0;
  logic        out_vld;
  logic [9:0]  out_x;
  logic [9:0]  out_y;
  logic        out_corner;
  logic [12:0] out_score;
  logic        frame_done;

  always #5 clk = ~clk;

  nms_stream_window #(
    .COL_NUM(C), .ROW_NUM(ROWS), .NMS_SIZE(3), .SCORE_W(13), .COORD_W(10)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_sof(in_sof), .in_corner(in_corner), .in_score(in_score),
    .out_vld(out_vld), .out_x(out_x), .out_y(out_y), .out_corner(out_corner),
    .out_score(out_score), .frame_done(frame_done)
  );

  int tests = 0;
  int fails = 0;

  bit fc [N];
  int fs [N];
  bit cap_c [N];
  int cap_s [N];
  bit ref_c [N];
  int ref_s [N];
  int cap_cnt, order_err, done_cnt, done_idx, surv_cnt, mon_idx;
  int flush_low, diff_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output capture, sampled away from the active edge
  always @(negedge clk) begin
    if (out_vld) begin
      mon_idx = int'(out_y) * C + int'(out_x);
      if (mon_idx != cap_cnt) order_err++;
      if (mon_idx < N) begin
        cap_c[mon_idx] = out_corner;
        cap_s[mon_idx] = int'(out_score);
      end
      if (out_corner) surv_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_idx = mon_idx;
      end
      cap_cnt++;
    end else if (frame_done) begin
      done_cnt += 100;
    end
  end

  task automatic clear_cap();
    for (int i = 0; i < N; i++) begin
      cap_c[i] = 1'b0;
      cap_s[i] = 0;
    end
    cap_cnt = 0; order_err = 0; done_cnt = 0; done_idx = -1; surv_cnt = 0;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fc[i] = 1'b0;
      fs[i] = 0;
    end
  endtask

  task automatic set_px(input int x, input int y, input int s);
    fc[y*C+x] = 1'b1;
    fs[y*C+x] = s;
  endtask

  // Streams pixels [0, stop_at); a full frame also waits out the flush with
  // in_vld held high and counts ce cycles spent with in_rdy low.
  task automatic send_frame(input bit rnd_ce, input int stop_at);
    int idx;
    int guard;
    bit acc;
    idx = 0;
    guard = 0;
    flush_low = 0;
    while (idx < stop_at && guard < 5000) begin
      @(negedge clk);
      ce        = rnd_ce ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_vld    = 1'b1;
      in_sof    = (idx == 0);
      in_corner = fc[idx];
      in_score  = 13'(fs[idx]);
      acc       = ce && in_rdy;
      @(posedge clk);
      if (acc) idx++;
      guard++;
    end
    check("pixels_accepted", idx, stop_at);
    if (stop_at == N) begin
      guard = 0;
      in_sof = 1'b0;
      forever begin
        @(negedge clk);
        if (in_rdy || guard >= 1000) begin
          in_vld = 1'b0;
          break;
        end
        ce = rnd_ce ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (ce) flush_low++;
        guard++;
      end
      check("flush_terminates", int'(guard < 1000), 1);
      ce = 1'b1;
      repeat (6) @(negedge clk);
    end
    in_vld = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int exp_surv, input int ia, input int sa);
    check({tag, "_pulses"}, cap_cnt, N);
    check({tag, "_order"}, order_err, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_idx"}, done_idx, N - 1);
    check({tag, "_survivors"}, surv_cnt, exp_surv);
    if (ia >= 0) begin
      check({tag, "_surv_corner"}, int'(cap_c[ia]), 1);
      check({tag, "_surv_score"}, cap_s[ia], sa);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_rdy", int'(in_rdy), 0);
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_out_x", int'(out_x), 0);
    check("rst_out_y", int'(out_y), 0);
    check("rst_out_corner", int'(out_corner), 0);
    check("rst_out_score", int'(out_score), 0);
    check("rst_frame_done", int'(frame_done), 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_rdy_ce_low", int'(in_rdy), 0);
    ce = 1'b1;
    @(negedge clk);
    check("idle_rdy_after_ce", int'(in_rdy), 1);

    // Single corner
    clear_cap(); clear_frame();
    set_px(3, 2, 100);
    send_frame(1'b0, N);
    check_frame("single", 1, 2*C+3, 100);
    check("single_flush_rdy_low", flush_low, 9);
    check("single_bg_score", cap_s[0], 0);

    // Pair: higher score wins
    clear_cap(); clear_frame();
    set_px(3, 2, 50); set_px(4, 2, 80);
    send_frame(1'b0, N);
    check_frame("pair_a", 1, 2*C+4, 80);
    check("pair_a_loser_score", cap_s[2*C+3], 50);
    for (int i = 0; i < N; i++) begin
      ref_c[i] = cap_c[i];
      ref_s[i] = cap_s[i];
    end

    clear_cap(); clear_frame();
    set_px(3, 2, 80); set_px(4, 2, 50);
    send_frame(1'b0, N);
    check_frame("pair_b", 1, 2*C+3, 80);

    // Equal plateau: earliest in raster order survives
    clear_cap(); clear_frame();
    set_px(2, 2, 60); set_px(3, 2, 60); set_px(2, 3, 60); set_px(3, 3, 60);
    send_frame(1'b0, N);
    check_frame("plateau", 1, 2*C+2, 60);

    // Frame corners
    clear_cap(); clear_frame();
    set_px(0, 0, 10); set_px(7, 5, 10);
    send_frame(1'b0, N);
`ifdef NMS_BORDER_SUPPRESS_EN
    check_frame("border", 0, -1, 0);
`else
    check_frame("border", 2, 0, 10);
    check("border_last_corner", int'(cap_c[N-1]), 1);
`endif

    // Random clock enable must not change the output sequence
    clear_cap(); clear_frame();
    set_px(3, 2, 50); set_px(4, 2, 80);
    send_frame(1'b1, N);
    check_frame("rand_ce", 1, 2*C+4, 80);
    check("rand_ce_flush_rdy_low", flush_low, 9);
    diff_cnt = 0;
    for (int i = 0; i < N; i++)
      if (ref_c[i] != cap_c[i] || ref_s[i] != cap_s[i]) diff_cnt++;
    check("rand_ce_seq_diff", diff_cnt, 0);

    // Reset mid-row 3 of a frame full of strong corners, then a fresh frame
    clear_frame();
    for (int i = 0; i < N; i++) begin
      fc[i] = 1'b1;
      fs[i] = 500 + i;
    end
    send_frame(1'b0, 3*C+4);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_vld", int'(out_vld), 0);
    check("midrst_in_rdy", int'(in_rdy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_cap(); clear_frame();
    set_px(1, 1, 5);
    send_frame(1'b0, N);
    check_frame("restart", 1, C+1, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
